// File: rtl/uart_rx_store_pkg.sv
// Shared definitions for the UART receive-and-store stage: FSM encoding and
// the frame geometry that the readback stage also relies on.
package uart_rx_store_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam int DEFAULT_ADDR_WIDTH = 16;
  localparam int DEFAULT_NUM_BYTES  = 65536;

endpackage

// File: rtl/uart_rx_store_if.sv
// Byte-in / RAM-write-out bundle of the receive-and-store stage. The slave
// modport is the store block itself; master is the surrounding system.
interface uart_rx_store_if
  import uart_rx_store_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);

  logic                  Start;
  logic                  Rx_DV;
  logic [7:0]            Rx_Byte;
  logic                  Wen;
  logic [ADDR_WIDTH-1:0] Addr;
  logic [7:0]            Wdata;
  logic [ADDR_WIDTH:0]   Count;
  logic [7:0]            Sum;
  logic                  fin;
  logic                  err;

  modport master (
    output Start, Rx_DV, Rx_Byte,
    input  Wen, Addr, Wdata, Count, Sum, fin, err
  );

  modport slave (
    input  Start, Rx_DV, Rx_Byte,
    output Wen, Addr, Wdata, Count, Sum, fin, err
  );

endinterface

// File: rtl/uart_rx_timeout.sv
// Saturating inter-byte watchdog. expired flags the edge on which the count
// would reach TIMEOUT_CYCLES, so the FSM can leave RECV on that same edge.
module uart_rx_timeout #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LIMIT    = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LIMIT_M1 = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [CW-1:0] count;

  // NOTE: sequential state is assigned with <= so every flop samples
  // pre-edge values; the reset here is synchronous, so it lives inside the
  // clocked branch rather than in the sensitivity list.
  always_ff @(posedge i_Clock) begin
    if (i_Reset || clear) begin
      count <= '0;
    end else if (enable && count != LIMIT) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (TIMEOUT_CYCLES != 0) && enable && (count == LIMIT_M1);

endmodule

// File: rtl/uart_rx_store.sv
// Writes a frame of UART bytes into RAM at sequential addresses, keeping a
// byte count and modulo-256 checksum, and flags completion or timeout.
module uart_rx_store
  import uart_rx_store_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int NUM_BYTES      = DEFAULT_NUM_BYTES,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic            i_Clock,
  input  logic            i_Reset,
  uart_rx_store_if.slave  bus
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(NUM_BYTES);

  state_t                state;
  logic                  wen;
  logic [ADDR_WIDTH-1:0] addr;
  logic [7:0]            wdata;
  logic [CNT_W-1:0]      count;
  logic [7:0]            sum;
  logic                  fin;
  logic                  err;

  logic             start_accept;
  logic             byte_accept;
  logic             expired;
  logic [CNT_W-1:0] count_next;

  assign start_accept = (state != RECV) && !bus.Start;
  assign byte_accept  = (state == RECV) && bus.Rx_DV;
  assign count_next   = count + 1'b1;

  uart_rx_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .enable  (state == RECV),
    .clear   (start_accept || byte_accept),
    .expired (expired)
  );

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state <= IDLE;
      wen   <= 1'b0;
      addr  <= '0;
      wdata <= '0;
      count <= '0;
      sum   <= '0;
      fin   <= 1'b0;
      err   <= 1'b0;
    end else begin
      // NOTE: Wen defaults low every clock so it can only ever be a
      // single-cycle pulse per accepted byte.
      wen <= 1'b0;
      unique case (state)
        IDLE, DONE, ERR: begin
          if (!bus.Start) begin
            state <= RECV;
            count <= '0;
            sum   <= '0;
            fin   <= 1'b0;
            err   <= 1'b0;
          end
        end
        RECV: begin
          // A strobe on the same edge as the timeout still counts as a byte.
          if (bus.Rx_DV) begin
            wen   <= 1'b1;
            wdata <= bus.Rx_Byte;
            addr  <= count[ADDR_WIDTH-1:0];
            sum   <= sum + bus.Rx_Byte;
            count <= count_next;
            if (count_next == FRAME_LEN) begin
              state <= DONE;
              fin   <= 1'b1;
            end
          end else if (expired) begin
            state <= ERR;
            err   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Wen   = wen;
  assign bus.Addr  = addr;
  assign bus.Wdata = wdata;
  assign bus.Count = count;
  assign bus.Sum   = sum;
  assign bus.fin   = fin;
  assign bus.err   = err;

endmodule

// File: doc/uart_rx_store.md
Name: uart_rx_store

Overview:
- Upstream neighbour of the memory-readback/transmit stage.
- Consumes byte strobes from the UART receiver and writes each byte into the frame RAM at sequential addresses starting at 0.
- Asserts fin once a full frame is stored, so the downsampling/readback stages can begin.
- Tracks an 8-bit running checksum and flags inter-byte timeouts.

Parameters:
ADDR_WIDTH, 16, RAM address width.
NUM_BYTES, 65536, bytes per frame; must satisfy 1 <= NUM_BYTES <= 2^ADDR_WIDTH.
TIMEOUT_CYCLES, 1000000, max clocks allowed between bytes while receiving; 0 disables the timeout.

Ports:
i_Clock  in  1  system clock, single domain.
i_Reset  in  1  synchronous, active-high reset.
Start  in  1  active-low start request, level-sampled.
Rx_DV  in  1  one-clock strobe from the UART receiver: Rx_Byte is valid.
Rx_Byte  in  8  received byte.
Wen  out  1  RAM write enable, one clock per byte.
Addr  out  ADDR_WIDTH  RAM write address.
Wdata  out  8  RAM write data.
Count  out  ADDR_WIDTH+1  bytes stored in the current frame.
Sum  out  8  modulo-256 sum of bytes stored in the current frame.
fin  out  1  frame complete; held high.
err  out  1  timeout occurred; held high.

Behaviour:
- Reset (i_Reset high at a clock edge):
  - State becomes IDLE.
  - Wen, Addr, Wdata, Count, Sum, fin, err and the timeout counter all become 0.
  - Reset wins over every other event. A reset mid-frame abandons the frame; RAM contents are untouched.
- States:
  - IDLE: waits for Start==0 at a clock edge, then goes to RECV. On that edge Count, Sum and the timeout counter clear, and fin and err clear.
  - RECV: accepts bytes (rules below).
  - DONE: fin=1. Stays until Start==0, which behaves exactly as in IDLE (starts a new frame).
  - ERR: err=1, fin=0. Stays until Start==0, which behaves as in IDLE.
- Write pipeline (RECV only):
  - When Rx_DV==1 at edge k, the registered outputs at edge k are Wen=1, Wdata=Rx_Byte, Addr=Count[ADDR_WIDTH-1:0], Sum=Sum+Rx_Byte (mod 256), Count=Count+1.
  - Wen falls at edge k+1 unless Rx_DV is high again.
  - Latency is one clock from strobe to write.
  - Back-to-back strobes on consecutive clocks are each written. No byte is lost and no hold register is needed.
- Frame completion:
  - If the byte accepted at edge k makes Count==NUM_BYTES, the state becomes DONE and fin=1 from edge k. The last write (Wen=1) is visible in the same cycle fin rises.
  - Addr never exceeds NUM_BYTES-1. With NUM_BYTES=2^ADDR_WIDTH, Count reaches 2^ADDR_WIDTH, which is why Count is one bit wider than Addr.
- Timeout (TIMEOUT_CYCLES>0):
  - In RECV the counter increments every clock and clears on every accepted Rx_DV.
  - When it reaches TIMEOUT_CYCLES with no strobe on that edge, the state becomes ERR and err=1.
  - If a strobe and the timeout coincide, the strobe wins: the byte is written and the counter clears.
  - The counter saturates and does not run outside RECV.
- Ignored inputs:
  - Rx_DV in IDLE, DONE or ERR is ignored: Wen stays 0, Count and Sum are unchanged.
  - Start==0 during RECV is ignored; a frame cannot restart mid-reception.
  - If Start is held low continuously, a new frame begins on the edge after DONE/ERR is entered. The system drives Start as a pulse.
  - Simultaneous Start==0 and Rx_DV in IDLE: the state goes to RECV and the byte is discarded.
- Hold behaviour:
  - Addr and Wdata hold their last values while Wen=0.
  - Count and Sum stay readable in DONE and ERR until the next start.

Decomposition:
- Shared package: state encoding (IDLE, RECV, DONE, ERR as a 2-bit typedef) and the default frame constants (ADDR_WIDTH=16, NUM_BYTES=65536). The readback stage uses the same frame constants.
- One natural sub-module: uart_rx_timeout, the saturating inter-byte watchdog counter. Inputs are enable, clear and i_Reset; output is expired.
- Everything else (FSM, address/count/sum registers) stays in the top.

Test Plan:
1. Basic frame:
   - Setup: NUM_BYTES=4, TIMEOUT_CYCLES=100. Reset, pulse Start low, then Rx_DV strobes with bytes 0x3B, 0x01, 0xFF, 0x10 spaced 20 clocks apart.
   - Required: four single-clock Wen pulses at Addr 0,1,2,3 with matching Wdata, each one clock after its strobe; fin=1 with the 4th write; Count=4, Sum=0x4B; err=0.
2. Back-to-back strobes:
   - Stimulus: 4 strobes on consecutive clocks with bytes 0x11..0x14.
   - Required: Wen high for 4 consecutive clocks, Addr 0..3, Sum=0x4A, fin on the 4th.
3. Timeout:
   - Stimulus: start, send 2 bytes, then silence.
   - Required: err=1 exactly 100 clocks after the 2nd strobe edge; fin=0; Count=2.
   - Then pulse Start: err clears, Count=0, and a new 4-byte frame completes normally.
4. Ignored events:
   - Stimulus: strobes before Start and after fin; a Start pulse mid-frame.
   - Required: no Wen before Start or after fin; the mid-frame Start does not reset Count.
5. Reset mid-frame:
   - Stimulus: assert i_Reset for 1 clock after 2 bytes.
   - Required: all outputs 0 and state IDLE on the next edge. A following Start plus 4 bytes writes Addr 0..3 again.
6. Timeout/strobe coincidence:
   - Stimulus: a strobe exactly on the 100th idle clock.
   - Required: the byte is written, err stays 0, and the counter restarts.
